// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and defaults for the MIPS pipeline stages
package pipeline_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0]       RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [31:0]       pc4_d,
  input  logic [INST_W-1:0] inst_d,
  output logic              valid,
  output logic [31:0]       pc4,
  output logic [INST_W-1:0] inst
);

  // Bubble wins over load; with neither asserted the register holds.
  // pc4 is left untouched by a bubble since valid=0 marks it meaningless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc4   <= 32'h0000_0000;
      inst  <= NOP_INST;
    end else if (bubble) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc4   <= pc4_d;
      inst  <= inst_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM, skid buffer, IF/ID
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0]       RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       branch_target_i,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [31:0]       pc_o,
  output logic              ifid_valid_o,
  output logic [31:0]       ifid_pc4_o,
  output logic [INST_W-1:0] ifid_inst_o
);

  fetch_state_t      state, state_n;
  logic [31:0]       pc, pc_n, pc_plus4;
  logic [INST_W-1:0] skid_inst;
  logic [31:0]       skid_pc4;
  logic              skid_cap;
  logic              ifid_load, ifid_bubble;
  logic [31:0]       ifid_pc4_d;
  logic [INST_W-1:0] ifid_inst_d;

  assign pc_plus4    = pc + 32'd4;
  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;
  assign pc_o        = pc;

  // State, PC and skid buffer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      skid_inst <= NOP_INST;
      skid_pc4  <= 32'h0000_0000;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (skid_cap) begin
        skid_inst <= imem_data_i;
        skid_pc4  <= pc_plus4;
      end
    end
  end

  // Next state, next PC and IF/ID controls; flush and stop override the
  // normal fetch decisions so that ack data is dropped in those cycles.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    skid_cap    = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pc4_d  = pc_plus4;
    ifid_inst_d = imem_data_i;

    case (state)
      IDLE: begin
        ifid_bubble = 1'b1;
        if (start_i) state_n = REQ;
      end
      REQ: begin
        if (imem_ack_i && !stall_i) begin
          ifid_load = 1'b1;
          pc_n      = pc_plus4;
        end else if (imem_ack_i && stall_i) begin
          skid_cap = 1'b1;
          state_n  = HOLD;
        end else if (!stall_i) begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          ifid_load   = 1'b1;
          ifid_pc4_d  = skid_pc4;
          ifid_inst_d = skid_inst;
          pc_n        = pc_plus4;
          state_n     = REQ;
        end
      end
      default: begin
        state_n     = IDLE;
        ifid_bubble = 1'b1;
      end
    endcase

    if (state != IDLE) begin
      if (flush_i) begin
        pc_n        = {branch_target_i[31:2], 2'b00};
        ifid_bubble = 1'b1;
        ifid_load   = 1'b0;
        skid_cap    = 1'b0;
        state_n     = REQ;
      end
      if (!start_i) begin
        if (!flush_i) pc_n = pc;
        ifid_bubble = 1'b1;
        ifid_load   = 1'b0;
        skid_cap    = 1'b0;
        state_n     = IDLE;
      end
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .pc4_d  (ifid_pc4_d),
    .inst_d (ifid_inst_d),
    .valid  (ifid_valid_o),
    .pc4    (ifid_pc4_o),
    .inst   (ifid_inst_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc;
  logic        valid;
  logic [31:0] pc4;
  logic [31:0] inst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (target),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_data_i     (data),
    .pc_o            (pc),
    .ifid_valid_o    (valid),
    .ifid_pc4_o      (pc4),
    .ifid_inst_o     (inst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
    target = 32'h0; ack = 1'b0; data = 32'h0;
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    tick;
    rst = 1'b0;
    tick;

    // start -> REQ, then two back-to-back acks
    start = 1'b1;
    tick;
    check("req_on", {31'b0, req}, 32'h1);
    check("addr0", addr, 32'h0);
    ack = 1'b1; data = 32'h2008_0005;
    tick;
    check("f1_valid", {31'b0, valid}, 32'h1);
    check("f1_pc4", pc4, 32'h4);
    check("f1_inst", inst, 32'h2008_0005);
    data = 32'h2009_0003;
    tick;
    check("f2_pc4", pc4, 32'h8);
    check("f2_inst", inst, 32'h2009_0003);
    check("f2_pc", pc, 32'h8);

    // ack under stall -> HOLD for 3 cycles, then release
    data = 32'h8D28_0000; stall = 1'b1;
    tick;
    ack = 1'b0; data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("hold_req", {31'b0, req}, 32'h0);
      check("hold_inst", inst, 32'h2009_0003);
      check("hold_pc", pc, 32'h8);
      if (i < 2) tick;
    end
    stall = 1'b0;
    tick;
    check("rel_inst", inst, 32'h8D28_0000);
    check("rel_pc4", pc4, 32'hC);
    check("rel_valid", {31'b0, valid}, 32'h1);
    check("rel_addr", addr, 32'hC);
    check("rel_req", {31'b0, req}, 32'h1);

    // flush during ack drops the data and aligns the target
    ack = 1'b1; data = 32'hDEAD_BEEF; flush = 1'b1; target = 32'h0000_0043;
    tick;
    flush = 1'b0;
    check("fl_valid", {31'b0, valid}, 32'h0);
    check("fl_inst", inst, 32'h0);
    check("fl_pc", pc, 32'h40);
    check("fl_addr", addr, 32'h40);

    // enter HOLD, then flush with stall still high
    data = 32'h1111_1111; stall = 1'b1;
    tick;
    check("h2_req", {31'b0, req}, 32'h0);
    ack = 1'b0; flush = 1'b1; target = 32'h0000_0100;
    tick;
    flush = 1'b0;
    check("fh_pc", pc, 32'h100);
    check("fh_req", {31'b0, req}, 32'h1);
    check("fh_valid", {31'b0, valid}, 32'h0);
    stall = 1'b0; ack = 1'b1; data = 32'h2222_2222;
    tick;
    check("fh_inst", inst, 32'h2222_2222);
    check("fh_pc4", pc4, 32'h104);

    // PC wrap
    ack = 1'b0; flush = 1'b1; target = 32'hFFFF_FFFC;
    tick;
    flush = 1'b0;
    check("wr_pc", pc, 32'hFFFF_FFFC);
    ack = 1'b1; data = 32'h3333_3333;
    tick;
    check("wr_pc4", pc4, 32'h0);
    check("wr_pcz", pc, 32'h0);
    check("wr_inst", inst, 32'h3333_3333);

    // four cycles without ack -> four bubbles, PC held
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("nb_valid", {31'b0, valid}, 32'h0);
      check("nb_inst", inst, 32'h0);
      check("nb_pc", pc, 32'h0);
    end

    // stop then restart refetches the same PC
    start = 1'b0; ack = 1'b1; data = 32'h5555_5555;
    tick;
    ack = 1'b0;
    check("stop_req", {31'b0, req}, 32'h0);
    check("stop_pc", pc, 32'h0);
    check("stop_valid", {31'b0, valid}, 32'h0);
    start = 1'b1;
    tick;
    check("restart_addr", addr, 32'h0);
    check("restart_req", {31'b0, req}, 32'h1);

    // async reset mid-REQ
    ack = 1'b1; data = 32'h4444_4444;
    tick;
    check("pre_rst_pc", pc, 32'h4);
    check("pre_rst_valid", {31'b0, valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("ar_pc", pc, 32'h0);
    check("ar_req", {31'b0, req}, 32'h0);
    check("ar_valid", {31'b0, valid}, 32'h0);
    check("ar_inst", inst, 32'h0);
    check("ar_pc4", pc4, 32'h0);
    ack = 1'b0;
    tick;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
